// File: rtl/parking_input_conditioner.sv
// Input front-end for the parking controller: synchronises and debounces the raw
// sensors and enter key, and assembles a two-digit password from the dial.
module parking_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       raw_entrance,
    input  logic       raw_exit,
    input  logic       raw_enter_key,
    input  logic [1:0] dial,
    output logic       sensor_entrance,
    output logic       sensor_exit,
    output logic [1:0] password_1,
    output logic [1:0] password_2,
    output logic       password_valid,
    output logic [1:0] entry_state
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TIME_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        GOT_FIRST = 2'b01,
        READY     = 2'b10
    } entry_state_t;

    // Bit order: {dial[1:0], enter_key, exit, entrance}.
    logic [4:0] sync_meta;
    logic [4:0] sync_q;

    // NOTE: every clocked register uses non-blocking assignment so all flops
    // sample pre-edge values, which is what makes the two-stage chain a chain.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= {dial, raw_enter_key, raw_exit, raw_entrance};
            sync_q    <= sync_meta;
        end
    end

    logic [1:0] dial_s;
    logic [2:0] deb_pulse;
    logic       enter_rise;

    assign dial_s = sync_q[4:3];

    for (genvar i = 0; i < 3; i++) begin : g_debounce
        logic [DW-1:0] cnt;
        logic          level;
        logic          pulse;
        logic          rise;

        assign rise = sync_q[i] && !level && (cnt == DEB_LAST);

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                cnt   <= '0;
                level <= 1'b0;
                pulse <= 1'b0;
            end else begin
                pulse <= rise;
                if (sync_q[i] == level) begin
                    cnt <= '0;
                end else if (cnt == DEB_LAST) begin
                    level <= sync_q[i];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign deb_pulse[i] = pulse;
        if (i == 2) begin : g_enter
            assign enter_rise = rise;
        end
    end

    logic enter_p;
    logic exit_p;
    assign enter_p = deb_pulse[2];
    assign exit_p  = deb_pulse[1];

    // Digit is captured on the edge that raises enter_p; the FSM consumes it one cycle later.
    logic [1:0] dial_cap;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)       dial_cap <= 2'b00;
        else if (enter_rise) dial_cap <= dial_s;
    end

    entry_state_t  state_q, state_d;
    logic [1:0]    d1_q, d1_d, d2_q, d2_d;
    logic          valid_q, valid_d;
    logic [TW-1:0] tcnt_q, tcnt_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            d1_q    <= 2'b00;
            d2_q    <= 2'b00;
            valid_q <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            valid_q <= valid_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        valid_d = valid_q;
        tcnt_d  = '0;
        case (state_q)
            IDLE: begin
                if (enter_p) begin
                    d1_d    = dial_cap;
                    state_d = GOT_FIRST;
                end
            end
            GOT_FIRST: begin
                if (enter_p) begin
                    d2_d    = dial_cap;
                    valid_d = 1'b1;
                    state_d = READY;
                end else if (tcnt_q == TIME_LAST) begin
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            READY: begin
                // A passing car consumes the password even if a new entry starts on the same edge.
                if (exit_p) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else if (enter_p) begin
                    d1_d    = dial_cap;
                    valid_d = 1'b0;
                    state_d = GOT_FIRST;
                end else if (tcnt_q == TIME_LAST) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign sensor_entrance = deb_pulse[0];
    assign sensor_exit     = exit_p;
    assign password_valid  = valid_q;
    assign password_1      = valid_q ? d1_q : 2'b00;
    assign password_2      = valid_q ? d2_q : 2'b00;
    assign entry_state     = state_q;

endmodule

// File: tb/tb_parking_input_conditioner.sv
// Directed bench for parking_input_conditioner with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20.
module tb_parking_input_conditioner;

    localparam int DEB = 4;
    localparam int TMO = 20;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       raw_entrance = 1'b0;
    logic       raw_exit = 1'b0;
    logic       raw_enter_key = 1'b0;
    logic [1:0] dial = 2'b00;
    logic       sensor_entrance;
    logic       sensor_exit;
    logic [1:0] password_1;
    logic [1:0] password_2;
    logic       password_valid;
    logic [1:0] entry_state;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clock = ~clock;

    parking_input_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .raw_entrance   (raw_entrance),
        .raw_exit       (raw_exit),
        .raw_enter_key  (raw_enter_key),
        .dial           (dial),
        .sensor_entrance(sensor_entrance),
        .sensor_exit    (sensor_exit),
        .password_1     (password_1),
        .password_2     (password_2),
        .password_valid (password_valid),
        .entry_state    (entry_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_entry(input string tag, input logic [1:0] st, input logic vld,
                               input logic [1:0] p1, input logic [1:0] p2);
        check({tag, "_state"}, 32'(entry_state), 32'(st));
        check({tag, "_valid"}, 32'(password_valid), 32'(vld));
        check({tag, "_pw1"}, 32'(password_1), 32'(p1));
        check({tag, "_pw2"}, 32'(password_2), 32'(p2));
    endtask

    // enter_p is acted on by the FSM 9 edges after the task starts; the task spans 17 edges.
    task automatic press_enter(input logic [1:0] d);
        dial = d;
        tick(2);
        raw_enter_key = 1'b1;
        tick(8);
        raw_enter_key = 1'b0;
        tick(7);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int npulse;
        int first_k;

        // Reset state
        #1;
        check_entry("rst", 2'b00, 1'b0, 2'b00, 2'b00);
        check("rst_entr", 32'(sensor_entrance), 0);
        check("rst_exit", 32'(sensor_exit), 0);
        tick(3);
        reset_n = 1'b1;
        tick(5);

        // Clean press on raw_entrance: single pulse 6 edges after the drive point
        npulse  = 0;
        first_k = -1;
        raw_entrance = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            tick(1);
            if (sensor_entrance) begin
                npulse++;
                if (first_k < 0) first_k = k;
            end
        end
        raw_entrance = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (sensor_entrance) npulse++;
        end
        check("entr_pulse_count", 32'(npulse), 1);
        check("entr_pulse_cycle", 32'(first_k), 6);

        // Glitch rejection on raw_exit: 3 high, 1 low, 3 high, then low
        npulse = 0;
        for (int p = 0; p < 4; p++) begin
            raw_exit = (p % 2 == 0);
            for (int k = 0; k < ((p == 1) ? 1 : ((p == 3) ? 12 : 3)); k++) begin
                tick(1);
                if (sensor_exit) npulse++;
            end
        end
        check("glitch_pulses", 32'(npulse), 0);

        // Password entry 00 then 11, consumed by an exit pulse
        press_enter(2'b00);
        check_entry("pw_first", 2'b01, 1'b0, 2'b00, 2'b00);
        press_enter(2'b11);
        check_entry("pw_ready", 2'b10, 1'b1, 2'b00, 2'b11);
        raw_exit = 1'b1;
        tick(5);
        check("exit_pre", 32'(sensor_exit), 0);
        tick(1);
        check("exit_pulse", 32'(sensor_exit), 1);
        check("exit_state_hold", 32'(entry_state), 32'(2'b10));
        tick(1);
        check("exit_pulse_end", 32'(sensor_exit), 0);
        check_entry("pw_consumed", 2'b00, 1'b0, 2'b00, 2'b00);
        raw_exit = 1'b0;
        tick(7);

        // Timeout in GOT_FIRST: GOT_FIRST entered 8 edges before the task returns
        press_enter(2'b01);
        check_entry("to1_first", 2'b01, 1'b0, 2'b00, 2'b00);
        tick(11);
        check("to1_before", 32'(entry_state), 32'(2'b01));
        tick(1);
        check_entry("to1_after", 2'b00, 1'b0, 2'b00, 2'b00);

        // Timeout in READY with distinct digits
        press_enter(2'b10);
        press_enter(2'b01);
        check_entry("to2_ready", 2'b10, 1'b1, 2'b10, 2'b01);
        tick(11);
        check_entry("to2_before", 2'b10, 1'b1, 2'b10, 2'b01);
        tick(1);
        check_entry("to2_after", 2'b00, 1'b0, 2'b00, 2'b00);

        // Simultaneous exit and enter pulses in READY: exit wins
        press_enter(2'b01);
        press_enter(2'b11);
        check_entry("sim_ready", 2'b10, 1'b1, 2'b01, 2'b11);
        raw_exit      = 1'b1;
        raw_enter_key = 1'b1;
        tick(6);
        check("sim_exit_pulse", 32'(sensor_exit), 1);
        tick(1);
        check_entry("sim_after", 2'b00, 1'b0, 2'b00, 2'b00);
        raw_exit      = 1'b0;
        raw_enter_key = 1'b0;
        tick(7);
        check("sim_settled", 32'(entry_state), 32'(2'b00));

        // Asynchronous reset mid-entry with raw inputs toggling
        press_enter(2'b10);
        press_enter(2'b01);
        press_enter(2'b11);
        check("rst2_pre", 32'(entry_state), 32'(2'b01));
        #2;
        reset_n      = 1'b0;
        raw_entrance = 1'b1;
        raw_exit     = 1'b1;
        #1;
        check_entry("rst2_async", 2'b00, 1'b0, 2'b00, 2'b00);
        for (int k = 0; k < 6; k++) begin
            raw_entrance  = ~raw_entrance;
            raw_exit      = ~raw_exit;
            raw_enter_key = ~raw_enter_key;
            dial          = 2'(k);
            tick(1);
        end
        check_entry("rst2_held", 2'b00, 1'b0, 2'b00, 2'b00);
        raw_entrance  = 1'b0;
        raw_exit      = 1'b0;
        raw_enter_key = 1'b0;
        reset_n       = 1'b1;
        npulse = 0;
        for (int k = 0; k < 25; k++) begin
            tick(1);
            if (sensor_entrance || sensor_exit || entry_state != 2'b00 || password_valid) npulse++;
        end
        check("rst2_quiet", 32'(npulse), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/parking_input_conditioner.md
Name: parking_input_conditioner

Overview:
- Front-end stage that feeds the parking FSM controller.
- Takes raw, bouncy, asynchronous push-button and sensor inputs, plus a 2-bit dial switch.
- Produces clean single-cycle sensor pulses and a two-digit password entered in sequence, which drive the controller's sensor_entrance, sensor_exit, password_1 and password_2 inputs.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a debounced level changes (>=1).
- TIMEOUT_CYCLES, 1000, idle cycles after which a partial or completed password entry is discarded (>=1).

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- raw_entrance  input  1  raw entrance sensor, asynchronous.
- raw_exit  input  1  raw exit sensor, asynchronous.
- raw_enter_key  input  1  raw "enter digit" push-button, asynchronous.
- dial  input  2  raw 2-bit digit switch, asynchronous.
- sensor_entrance  output  1  one-cycle pulse on debounced rising edge of raw_entrance.
- sensor_exit  output  1  one-cycle pulse on debounced rising edge of raw_exit.
- password_1  output  2  first entered digit, gated by password_valid.
- password_2  output  2  second entered digit, gated by password_valid.
- password_valid  output  1  high while a complete two-digit entry is held.
- entry_state  output  2  entry FSM state: 00 IDLE, 01 GOT_FIRST, 10 READY.

Behaviour:
- Reset is asynchronous, active-low, clock is clock. While reset_n=0 all flops clear:
  - sync chains, debounced levels, counters = 0
  - all outputs 0, entry_state=IDLE
  - reset mid-entry discards everything immediately.
- Synchronisation: each raw input (raw_entrance, raw_exit, raw_enter_key, both dial bits) passes through a 2-flop synchroniser. The synchronised value is s.
- Debounce (per raw_entrance, raw_exit, raw_enter_key; independent instances), with level deb and counter cnt of width clog2(DEBOUNCE_CYCLES):
  - s==deb: cnt<=0.
  - s!=deb and cnt==DEBOUNCE_CYCLES-1: deb<=s, cnt<=0.
  - otherwise: cnt<=cnt+1.
  - Any mismatch gap restarts the count.
- Pulse generation:
  - The pulse is registered. It is high for exactly the one cycle following the edge where deb goes 0->1; a 1->0 transition gives no pulse.
  - Latency: raw first sampled high at edge N and held gives deb=1 and the pulse after edge N+1+DEBOUNCE_CYCLES.
  - A held input yields exactly one pulse.
- The debounced enter-key rising-edge pulse is enter_p (internal). The synchronised dial value is dial_s; dial is not debounced. The dial is sampled on the same edge that asserts enter_p, i.e. digit = dial_s at that edge.
- Entry FSM with timeout counter tcnt (width clog2(TIMEOUT_CYCLES+1)). tcnt clears on every state transition and on every enter_p, and increments each cycle in GOT_FIRST and READY.
  - IDLE: enter_p -> d1<=dial_s, GOT_FIRST.
  - GOT_FIRST:
    - enter_p -> d2<=dial_s, password_valid<=1, READY.
    - else tcnt==TIMEOUT_CYCLES-1 -> IDLE.
  - READY:
    - sensor_exit pulse -> IDLE, valid<=0 (car passed, password consumed).
    - else enter_p -> d1<=dial_s, valid<=0, GOT_FIRST (new entry).
    - else tcnt==TIMEOUT_CYCLES-1 -> IDLE, valid<=0.
- Priority on simultaneous events:
  - in READY: sensor_exit > enter_p > timeout.
  - in GOT_FIRST: enter_p > timeout.
- Outputs:
  - password_1 = valid ? d1 : 2'b00.
  - password_2 = valid ? d2 : 2'b00.
  - The gated 00/00 value never matches the controller's key 00/11, so an incomplete entry cannot open the gate.
  - All outputs are registered or derived only from registers; no combinational path from raw inputs.
- sensor_entrance and sensor_exit are passed to the outputs regardless of entry state.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20):
- Reset: assert reset_n=0 mid-GOT_FIRST with raw inputs toggling -> all outputs 0 and entry_state=00 immediately, asynchronously; after release nothing happens until new stimulus.
- Clean press: raw_entrance 0->1 sampled at edge 10 and held 50 cycles -> sensor_entrance=1 for exactly one cycle after edge 15, then stays 0; release gives no pulse.
- Glitch rejection: raw_exit high 3 cycles, low 1, high 3, low -> sensor_exit never pulses, debounced level stays 0.
- Password entry:
  - dial=00, press enter (held 8 cycles) -> entry_state=01, password_valid=0, password_1/2=00.
  - dial=11, press -> entry_state=10, password_valid=1, password_1=00, password_2=11.
  - raw_exit press -> one sensor_exit pulse, next cycle entry_state=00, valid=0, password_2=00.
- Timeouts:
  - after the first digit, no press for 20 cycles -> entry_state 01->00 at tcnt=19, valid stays 0.
  - in READY, 20 idle cycles -> valid drops to 0 and outputs return to 00.
- Simultaneous: in READY, enter_p and sensor_exit pulse on the same edge -> entry_state=00, not 01; valid=0.
